// File: rtl/clct_subkey_unpack.sv
// Receiver-side unpacker for the best-of-7 CLCT word: decodes the 1/8-strip subkey into
// CFEB/halfstrip/quarter/eighth-strip fields, flags clamps and range errors, buffers in a credit FIFO.
module clct_subkey_unpack #(
  parameter int unsigned MXXKYB     = 10,
  parameter int unsigned MXPATB     = 7,
  parameter int unsigned MXQLTB     = 6,
  parameter int unsigned MXBNDB     = 5,
  parameter int unsigned MXPATC     = 12,
  parameter int unsigned MXHSX      = 224,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNTW       = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [MXXKYB-1:0]               in_subkey,
  input  logic [MXPATB-1:0]               in_pat,
  input  logic [MXQLTB-1:0]               in_qlt,
  input  logic [MXBNDB-1:0]               in_bend,
  input  logic [MXPATC-1:0]               in_carry,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2:0]                      out_cfeb,
  output logic [4:0]                      out_key,
  output logic [MXXKYB-3:0]               out_hs,
  output logic                            out_qs,
  output logic                            out_es,
  output logic                            out_me1a,
  output logic                            out_edge,
  output logic                            out_err,
  output logic [MXPATB-1:0]               out_pat,
  output logic [MXQLTB-1:0]               out_qlt,
  output logic [MXBNDB-1:0]               out_bend,
  output logic [MXPATC-1:0]               out_carry,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [CNTW-1:0]                 cnt_decoded,
  output logic [CNTW-1:0]                 cnt_err,
  output logic [CNTW-1:0]                 cnt_edge
);

  localparam int unsigned HSW  = MXXKYB - 2;
  localparam int unsigned HSW1 = HSW + 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned CW1  = CW + 1;

  // Clamp values the selector can emit at the ME1/1b and ME1/1a boundaries
  localparam logic [MXXKYB-1:0] LP_EDGE_LO_B = MXXKYB'(0);
  localparam logic [MXXKYB-1:0] LP_EDGE_HI_B = MXXKYB'(4 * 127 + 3);
  localparam logic [MXXKYB-1:0] LP_EDGE_LO_A = MXXKYB'(4 * 128);
  localparam logic [MXXKYB-1:0] LP_EDGE_HI_A = MXXKYB'(4 * 223 + 3);
  localparam logic [HSW:0]      LP_HSX       = HSW1'(MXHSX);
  localparam logic [HSW-1:0]    LP_ME1A_HS   = HSW'(128);

  typedef struct packed {
    logic [2:0]        cfeb;
    logic [4:0]        key;
    logic [HSW-1:0]    hs;
    logic              qs;
    logic              es;
    logic              me1a;
    logic              is_edge;
    logic              err;
    logic [MXPATB-1:0] pat;
    logic [MXQLTB-1:0] qlt;
    logic [MXBNDB-1:0] bend;
    logic [MXPATC-1:0] carry;
  } entry_t;

  // Input decode
  logic           w_accept;
  logic [HSW-1:0] w_in_hs;
  logic           w_in_err;
  logic           w_in_edge;

  assign w_accept  = in_valid && in_ready;
  assign w_in_hs   = in_subkey[MXXKYB-1:2];
  assign w_in_err  = {1'b0, w_in_hs} >= LP_HSX;
  assign w_in_edge = (in_subkey == LP_EDGE_LO_B) || (in_subkey == LP_EDGE_HI_B) ||
                     (in_subkey == LP_EDGE_LO_A) || (in_subkey == LP_EDGE_HI_A);

  // Stage S1: raw split of the subkey plus flags
  logic              r_s1_valid;
  logic [HSW-1:0]    r_s1_hs;
  logic [1:0]        r_s1_offs;
  logic              r_s1_err;
  logic              r_s1_edge;
  logic [MXPATB-1:0] r_s1_pat;
  logic [MXQLTB-1:0] r_s1_qlt;
  logic [MXBNDB-1:0] r_s1_bend;
  logic [MXPATC-1:0] r_s1_carry;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_hs    <= '0;
      r_s1_offs  <= '0;
      r_s1_err   <= 1'b0;
      r_s1_edge  <= 1'b0;
      r_s1_pat   <= '0;
      r_s1_qlt   <= '0;
      r_s1_bend  <= '0;
      r_s1_carry <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_hs    <= w_in_hs;
        r_s1_offs  <= in_subkey[1:0];
        r_s1_err   <= w_in_err;
        r_s1_edge  <= w_in_edge;
        r_s1_pat   <= in_pat;
        r_s1_qlt   <= in_qlt;
        r_s1_bend  <= in_bend;
        r_s1_carry <= in_carry;
      end
    end
  end

  // Stage S2 decode; out-of-range halfstrips are steered to CFEB 7 in ME1/1a
  entry_t w_s2_next;

  always_comb begin
    w_s2_next         = '0;
    w_s2_next.hs      = r_s1_hs;
    w_s2_next.key     = r_s1_hs[4:0];
    w_s2_next.qs      = r_s1_offs[1];
    w_s2_next.es      = r_s1_offs[0];
    w_s2_next.is_edge = r_s1_edge;
    w_s2_next.err     = r_s1_err;
    w_s2_next.pat     = r_s1_pat;
    w_s2_next.qlt     = r_s1_qlt;
    w_s2_next.bend    = r_s1_bend;
    w_s2_next.carry   = r_s1_carry;
    if (r_s1_err) begin
      w_s2_next.cfeb = 3'd7;
      w_s2_next.me1a = 1'b1;
    end else begin
      w_s2_next.cfeb = r_s1_hs[HSW-1 -: 3];
      w_s2_next.me1a = (r_s1_hs >= LP_ME1A_HS);
    end
  end

  logic   r_s2_valid;
  entry_t r_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2 <= w_s2_next;
      end
    end
  end

  // Output FIFO, first-word-fall-through; credits guarantee a push never finds it full
  entry_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;
  entry_t          w_head;

  assign w_push = r_s2_valid;
  assign w_pop  = (r_count != '0) && out_ready;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_s2;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Credits: every entry in flight or stored holds one FIFO slot
  logic [CW:0] w_used;

  assign w_used   = CW1'(r_count) + CW1'(r_s1_valid) + CW1'(r_s2_valid);
  assign in_ready = w_used < CW1'(FIFO_DEPTH);

  // Saturating statistics, counted at FIFO write
  logic [CNTW-1:0] r_cnt_decoded;
  logic [CNTW-1:0] r_cnt_err;
  logic [CNTW-1:0] r_cnt_edge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_decoded <= '0;
      r_cnt_err     <= '0;
      r_cnt_edge    <= '0;
    end else if (w_push) begin
      if (r_cnt_decoded != {CNTW{1'b1}}) r_cnt_decoded <= r_cnt_decoded + CNTW'(1);
      if (r_s2.err && (r_cnt_err != {CNTW{1'b1}})) r_cnt_err <= r_cnt_err + CNTW'(1);
      if (r_s2.is_edge && (r_cnt_edge != {CNTW{1'b1}})) r_cnt_edge <= r_cnt_edge + CNTW'(1);
    end
  end

  assign out_valid   = (r_count != '0);
  assign out_cfeb    = w_head.cfeb;
  assign out_key     = w_head.key;
  assign out_hs      = w_head.hs;
  assign out_qs      = w_head.qs;
  assign out_es      = w_head.es;
  assign out_me1a    = w_head.me1a;
  assign out_edge    = w_head.is_edge;
  assign out_err     = w_head.err;
  assign out_pat     = w_head.pat;
  assign out_qlt     = w_head.qlt;
  assign out_bend    = w_head.bend;
  assign out_carry   = w_head.carry;
  assign fifo_count  = r_count;
  assign cnt_decoded = r_cnt_decoded;
  assign cnt_err     = r_cnt_err;
  assign cnt_edge    = r_cnt_edge;

endmodule

// File: tb/tb_clct_subkey_unpack.sv
// Directed bench for clct_subkey_unpack: table of hand-decoded subkeys plus
// back-to-back, backpressure and mid-operation reset sequences.
module tb_clct_subkey_unpack;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_subkey;
  logic [6:0]  in_pat;
  logic [5:0]  in_qlt;
  logic [4:0]  in_bend;
  logic [11:0] in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_cfeb;
  logic [4:0]  out_key;
  logic [7:0]  out_hs;
  logic        out_qs, out_es, out_me1a, out_edge, out_err;
  logic [6:0]  out_pat;
  logic [5:0]  out_qlt;
  logic [4:0]  out_bend;
  logic [11:0] out_carry;
  logic [2:0]  fifo_count;
  logic [15:0] cnt_decoded, cnt_err, cnt_edge;

  clct_subkey_unpack dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_subkey(in_subkey),
    .in_pat(in_pat), .in_qlt(in_qlt), .in_bend(in_bend), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cfeb(out_cfeb), .out_key(out_key), .out_hs(out_hs),
    .out_qs(out_qs), .out_es(out_es), .out_me1a(out_me1a),
    .out_edge(out_edge), .out_err(out_err),
    .out_pat(out_pat), .out_qlt(out_qlt), .out_bend(out_bend), .out_carry(out_carry),
    .fifo_count(fifo_count),
    .cnt_decoded(cnt_decoded), .cnt_err(cnt_err), .cnt_edge(cnt_edge)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sk; int pat; int hs; int cfeb; int key;
    int qs; int es; int me1a; int edg; int err;
  } vec_t;

  vec_t tv [11];
  int   n_checks = 0;
  int   n_err    = 0;
  int   e_dec    = 0;
  int   e_err    = 0;
  int   e_edge   = 0;
  int   j_col;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n);
    vec_t v;
    v.sk = 4 * (40 + n) + n; v.pat = 16 + n; v.hs = 40 + n; v.cfeb = 1; v.key = 8 + n;
    v.qs = (n >> 1) & 1; v.es = n & 1; v.me1a = 0; v.edg = 0; v.err = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_subkey = 10'(v.sk);
    in_pat    = 7'(v.pat);
    in_qlt    = 6'(v.sk + 3);
    in_bend   = 5'(v.sk + 7);
    in_carry  = 12'(v.sk * 5);
  endtask

  task automatic check_out(input vec_t v);
    string t;
    t = $sformatf("sk=%0d", v.sk);
    check({"out_valid ", t}, int'(out_valid), 1);
    check({"hs ", t},    int'(out_hs),   v.hs);
    check({"cfeb ", t},  int'(out_cfeb), v.cfeb);
    check({"key ", t},   int'(out_key),  v.key);
    check({"qs ", t},    int'(out_qs),   v.qs);
    check({"es ", t},    int'(out_es),   v.es);
    check({"me1a ", t},  int'(out_me1a), v.me1a);
    check({"edge ", t},  int'(out_edge), v.edg);
    check({"err ", t},   int'(out_err),  v.err);
    check({"pat ", t},   int'(out_pat),  v.pat);
    check({"qlt ", t},   int'(out_qlt),  (v.sk + 3) % 64);
    check({"bend ", t},  int'(out_bend), (v.sk + 7) % 32);
    check({"carry ", t}, int'(out_carry), (v.sk * 5) % 4096);
  endtask

  task automatic check_counters(input string tag);
    check({"cnt_decoded ", tag}, int'(cnt_decoded), e_dec);
    check({"cnt_err ", tag},     int'(cnt_err),     e_err);
    check({"cnt_edge ", tag},    int'(cnt_edge),    e_edge);
  endtask

  // Single transaction with out_ready=1: checks 3-clock latency and decode
  task automatic send_one(input vec_t v);
    int lat;
    @(posedge clock); #1;
    drive(v);
    check("in_ready before accept", int'(in_ready), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    check($sformatf("latency sk=%0d", v.sk), lat, 3);
    e_dec++;
    if (v.err != 0) e_err++;
    if (v.edg != 0) e_edge++;
    check_out(v);
    check_counters($sformatf("after sk=%0d", v.sk));
  endtask

  initial begin
    int n;
    int j;
    bit acc;
    bit first;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_subkey = '0; in_pat = '0; in_qlt = '0; in_bend = '0; in_carry = '0;

    //          sk    pat   hs   cfeb key qs es me1a edge err
    tv[0]  = '{150,  'h5A, 37,  1,   5,  1, 0, 0,   0,   0};
    tv[1]  = '{523,  'h21, 130, 4,   2,  1, 1, 1,   0,   0};
    tv[2]  = '{900,  'h3C, 225, 7,   1,  0, 0, 1,   0,   1};
    tv[3]  = '{509,  'h11, 127, 3,   31, 0, 1, 0,   0,   0};
    tv[4]  = '{513,  'h22, 128, 4,   0,  0, 1, 1,   0,   0};
    tv[5]  = '{896,  'h7F, 224, 7,   0,  0, 0, 1,   0,   1};
    tv[6]  = '{1023, 'h00, 255, 7,   31, 1, 1, 1,   0,   1};
    tv[7]  = '{0,    'h01, 0,   0,   0,  0, 0, 0,   1,   0};
    tv[8]  = '{511,  'h02, 127, 3,   31, 1, 1, 0,   1,   0};
    tv[9]  = '{512,  'h03, 128, 4,   0,  0, 0, 1,   1,   0};
    tv[10] = '{895,  'h04, 223, 6,   31, 1, 1, 1,   1,   0};

    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset fifo_count", int'(fifo_count), 0);
    check("reset out_hs", int'(out_hs), 0);
    check("reset out_pat", int'(out_pat), 0);
    check_counters("reset");

    // Isolated transactions
    for (int i = 0; i <= 6; i++) send_one(tv[i]);
    @(posedge clock); #1;
    check("drained out_valid", int'(out_valid), 0);
    check("drained fifo_count", int'(fifo_count), 0);

    // Back-to-back clamp values, full rate
    j_col = 7;
    fork
      begin
        for (int i = 7; i <= 10; i++) begin
          @(posedge clock); #1;
          drive(tv[i]);
          check("b2b in_ready", int'(in_ready), 1);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20 && j_col <= 10; c++) begin
          @(posedge clock); #1;
          if (out_valid) begin
            check_out(tv[j_col]);
            j_col++;
          end
        end
      end
    join
    check("b2b outputs seen", j_col, 11);
    e_dec += 4; e_edge += 4;
    check_counters("after edges");

    // Backpressure: out_ready low, in_valid held high
    @(posedge clock); #1;
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      drive(mk(n));
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
      if (acc) n++;
    end
    in_valid = 1'b0;
    check("bp accepts", n, 4);
    check("bp in_ready low", int'(in_ready), 0);
    check("bp fifo_count", int'(fifo_count), 4);

    out_ready = 1'b1;
    j = 0;
    first = 1'b1;
    for (int c = 0; c < 12 && j < 4; c++) begin
      if (out_valid) begin
        check_out(mk(j));
        j++;
      end
      @(posedge clock); #1;
      if (first) begin
        check("in_ready after first pop", int'(in_ready), 1);
        first = 1'b0;
      end
    end
    check("bp entries popped", j, 4);
    check("bp out_valid after drain", int'(out_valid), 0);
    check("bp fifo_count after drain", int'(fifo_count), 0);
    e_dec += 4;
    check_counters("after backpressure");

    // Reset with two entries in the FIFO and one in S1
    out_ready = 1'b0;
    drive(mk(0));
    @(posedge clock); #1;
    drive(mk(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    drive(mk(2));
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("pre-reset fifo_count", int'(fifo_count), 2);
    #2 reset = 1'b1;
    #1;
    check("mid reset out_valid", int'(out_valid), 0);
    check("mid reset fifo_count", int'(fifo_count), 0);
    e_dec = 0; e_err = 0; e_edge = 0;
    check_counters("mid reset");
    @(negedge clock) reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("post-release in_ready", int'(in_ready), 1);
    check("post-release out_valid", int'(out_valid), 0);
    send_one('{4, 'h33, 1, 0, 1, 0, 0, 0, 0, 0});
    @(posedge clock); #1;
    check("post-release nothing behind", int'(out_valid), 0);
    check("post-release fifo_count", int'(fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
